// File: rtl/hub75_fb_arbiter.sv
// HUB75 double-buffered framebuffer arbiter: display reads win over host
// writes on a single synchronous RAM port; page swaps wait for frame end.
module hub75_fb_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_wr_valid,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_ready,
    input  logic              swap_req,
    input  logic              frame_end,
    output logic              swap_done,
    output logic              front_page,
    output logic [ADDR_W:0]   ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SWAP
    } state_t;

    state_t state;
    state_t state_nx;

    logic rd_v1;
    logic rd_v2;
    logic wr_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A swap request arriving outside IDLE is dropped, not queued.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (swap_req)  state_nx = PENDING;
            PENDING: if (frame_end) state_nx = SWAP;
            SWAP:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    assign swap_done     = (state == SWAP);
    assign host_wr_ready = ~disp_req && (state == IDLE);
    assign wr_fire       = host_wr_valid && host_wr_ready;

    // Page flips on entry to SWAP so the new page is visible while swap_done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_page  <= 1'b0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
            rd_v1       <= 1'b0;
            rd_v2       <= 1'b0;
            disp_rvalid <= 1'b0;
            disp_rdata  <= '0;
        end else begin
            if (state == PENDING && frame_end) begin
                front_page <= ~front_page;
            end

            ram_we <= wr_fire;
            if (disp_req) begin
                ram_addr <= {front_page, disp_addr};
            end else if (wr_fire) begin
                ram_addr  <= {~front_page, host_wr_addr};
                ram_wdata <= host_wr_data;
            end

            rd_v1       <= disp_req;
            rd_v2       <= rd_v1;
            disp_rvalid <= rd_v2;
            if (rd_v2) begin
                disp_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Bench for hub75_fb_arbiter: directed scenarios plus a randomized run
// against a page/queue reference model with a synchronous RAM model.
module tb_hub75_fb_arbiter;

    localparam int AW   = 11;
    localparam int DW   = 24;
    localparam int RAMW = AW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          host_wr_valid;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_wr_ready;
    logic          swap_req;
    logic          frame_end;
    logic          swap_done;
    logic          front_page;
    logic [AW:0]   ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int tests = 0;
    int fails = 0;

    logic          mem_init;
    logic [DW-1:0] mem [0:(1<<RAMW)-1];

    always #5 clk = ~clk;

    hub75_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
        .swap_req(swap_req), .frame_end(frame_end),
        .swap_done(swap_done), .front_page(front_page),
        .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous RAM; init fills every word with its own address.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << RAMW); i++) mem[i] <= DW'(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic idle_inputs();
        disp_req = 0; disp_addr = '0;
        host_wr_valid = 0; host_wr_addr = '0; host_wr_data = '0;
        swap_req = 0; frame_end = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; mem_init = 1; ram_rdata = '0;
        idle_inputs();
        tick(); tick();
        mem_init = 0;
        tests++;
        if ({ram_we, ram_addr, ram_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_ram we=%b addr=%h wdata=%h exp 0/0/0",
                     ram_we, ram_addr, ram_wdata);
        end
        tests++;
        if ({disp_rvalid, disp_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_rd rvalid=%b rdata=%h exp 0/0",
                     disp_rvalid, disp_rdata);
        end
        tests++;
        if ({swap_done, front_page, host_wr_ready} !== 3'b001) begin
            fails++;
            $display("FAIL reset_ctl done/fp/rdy=%b%b%b exp 001",
                     swap_done, front_page, host_wr_ready);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_host_write();
        host_wr_valid = 1; host_wr_addr = 11'h005; host_wr_data = 24'hABCDEF;
        #1;
        tests++;
        if (host_wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL wr_ready got=%b exp=1", host_wr_ready);
        end
        tick();
        host_wr_valid = 0;
        tests++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 12'h805, 24'hABCDEF}) begin
            fails++;
            $display("FAIL wr_issue we=%b addr=%h wdata=%h exp 1/805/abcdef",
                     ram_we, ram_addr, ram_wdata);
        end
        tick();
        tests++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b0, 12'h805, 24'hABCDEF}) begin
            fails++;
            $display("FAIL wr_hold we=%b addr=%h wdata=%h exp 0/805/abcdef",
                     ram_we, ram_addr, ram_wdata);
        end
    endtask

    task automatic test_read_burst();
        logic exp_v;
        for (int k = 0; k < 8; k++) begin
            disp_req = (k < 4);
            disp_addr = AW'(k);
            host_wr_valid = (k < 4);
            host_wr_addr = AW'($urandom);
            host_wr_data = DW'($urandom);
            #1;
            if (k < 4) begin
                tests++;
                if (host_wr_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL burst_ready k=%0d got=%b exp=0", k, host_wr_ready);
                end
            end
            tick();
            tests++;
            if (ram_we !== 1'b0 || ram_addr !== 12'((k < 4) ? k : 3)) begin
                fails++;
                $display("FAIL burst_ram k=%0d we=%b addr=%h exp 0/%h",
                         k, ram_we, ram_addr, 12'((k < 4) ? k : 3));
            end
            exp_v = (k >= 2 && k <= 5);
            tests++;
            if (disp_rvalid !== exp_v || (exp_v && disp_rdata !== DW'(k - 2))) begin
                fails++;
                $display("FAIL burst_rd k=%0d rvalid=%b rdata=%h exp %b/%h",
                         k, disp_rvalid, disp_rdata, exp_v, DW'(k - 2));
            end
        end
        idle_inputs();
    endtask

    task automatic test_swap();
        swap_req = 1;
        tick();
        swap_req = 0;
        host_wr_valid = 1; host_wr_addr = 11'h007; host_wr_data = 24'h123456;
        for (int k = 0; k < 10; k++) begin
            frame_end = (k == 9);
            #1;
            tests++;
            if (host_wr_ready !== 1'b0) begin
                fails++;
                $display("FAIL swap_wait_rdy k=%0d got=%b exp=0", k, host_wr_ready);
            end
            tick();
            if (k < 9) begin
                tests++;
                if ({ram_we, swap_done, front_page} !== 3'b000) begin
                    fails++;
                    $display("FAIL swap_wait k=%0d we/done/fp=%b%b%b exp 000",
                             k, ram_we, swap_done, front_page);
                end
            end
        end
        frame_end = 0;
        tests++;
        if ({swap_done, front_page, host_wr_ready, ram_we} !== 4'b1100) begin
            fails++;
            $display("FAIL swap_apply done/fp/rdy/we=%b%b%b%b exp 1100",
                     swap_done, front_page, host_wr_ready, ram_we);
        end
        host_wr_valid = 0;
        tick();
        tests++;
        if ({swap_done, front_page, host_wr_ready} !== 3'b011) begin
            fails++;
            $display("FAIL swap_after done/fp/rdy=%b%b%b exp 011",
                     swap_done, front_page, host_wr_ready);
        end
        disp_req = 1; disp_addr = 11'h003;
        tick();
        disp_req = 0;
        tests++;
        if (ram_addr !== 12'h803) begin
            fails++;
            $display("FAIL swap_rd_addr got=%h exp=803", ram_addr);
        end
        tick(); tick();
        tests++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 24'h000803) begin
            fails++;
            $display("FAIL swap_rd_data rvalid=%b rdata=%h exp 1/000803",
                     disp_rvalid, disp_rdata);
        end
    endtask

    task automatic test_same_edge();
        swap_req = 1; frame_end = 1;
        tick();
        swap_req = 0; frame_end = 0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({swap_done, front_page, host_wr_ready} !== 3'b010) begin
                fails++;
                $display("FAIL same_edge k=%0d done/fp/rdy=%b%b%b exp 010",
                         k, swap_done, front_page, host_wr_ready);
            end
            tick();
        end
        frame_end = 1;
        tick();
        frame_end = 0;
        tests++;
        if ({swap_done, front_page} !== 2'b10) begin
            fails++;
            $display("FAIL same_edge_done done/fp=%b%b exp 10", swap_done, front_page);
        end
        tick();
        tests++;
        if ({swap_done, host_wr_ready} !== 2'b01) begin
            fails++;
            $display("FAIL same_edge_idle done/rdy=%b%b exp 01", swap_done, host_wr_ready);
        end
    endtask

    task automatic test_reset_mid();
        swap_req = 1; tick(); swap_req = 0;
        frame_end = 1; tick(); frame_end = 0;
        tick();
        disp_req = 1; disp_addr = 11'h001; swap_req = 1;
        tick();
        swap_req = 0;
        tick();
        disp_req = 0; rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            frame_end = (k == 1);
            #1;
            tests++;
            if ({disp_rvalid, swap_done, front_page, host_wr_ready} !== 4'b0001) begin
                fails++;
                $display("FAIL rst_mid k=%0d rv/done/fp/rdy=%b%b%b%b exp 0001",
                         k, disp_rvalid, swap_done, front_page, host_wr_ready);
            end
            tick();
        end
        frame_end = 0;
    endtask

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    task automatic test_random();
        logic [DW-1:0] shadow [0:(1<<RAMW)-1];
        rd_t           q[$];
        logic          m_fp = 0, m_pend = 0, m_swp = 0;
        logic          exp_rdy, exp_we, exp_v;
        logic [AW:0]   exp_addr = '0;
        logic [DW-1:0] exp_wdata = '0;
        for (int i = 0; i < (1 << RAMW); i++) shadow[i] = DW'(i);
        rst = 1; mem_init = 1;
        tick();
        rst = 0; mem_init = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            disp_req      = ($urandom % 2) == 0;
            disp_addr     = AW'($urandom % 16);
            host_wr_valid = ($urandom % 2) == 0;
            host_wr_addr  = AW'($urandom % 16);
            host_wr_data  = DW'($urandom);
            swap_req      = ($urandom % 12) == 0;
            frame_end     = ($urandom % 6) == 0;
            #1;
            exp_rdy = !disp_req && !m_pend && !m_swp;
            tests++;
            if (host_wr_ready !== exp_rdy) begin
                fails++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, host_wr_ready, exp_rdy);
            end
            @(posedge clk);
            exp_we = 0;
            if (disp_req) begin
                exp_addr = {m_fp, disp_addr};
                q.push_back('{due: cyc + 2, data: shadow[exp_addr]});
            end else if (host_wr_valid && exp_rdy) begin
                exp_we = 1;
                exp_addr = {~m_fp, host_wr_addr};
                exp_wdata = host_wr_data;
                shadow[exp_addr] = host_wr_data;
            end
            if (m_swp) begin
                m_swp = 0;
            end else if (m_pend && frame_end) begin
                m_pend = 0; m_swp = 1; m_fp = ~m_fp;
            end else if (!m_pend && swap_req) begin
                m_pend = 1;
            end
            #1;
            tests++;
            if (ram_we !== exp_we || ram_addr !== exp_addr || ram_wdata !== exp_wdata) begin
                fails++;
                $display("FAIL rnd_ram cyc=%0d we=%b addr=%h wd=%h exp %b/%h/%h",
                         cyc, ram_we, ram_addr, ram_wdata, exp_we, exp_addr, exp_wdata);
            end
            tests++;
            if (swap_done !== m_swp || front_page !== m_fp) begin
                fails++;
                $display("FAIL rnd_swap cyc=%0d done/fp=%b%b exp %b%b",
                         cyc, swap_done, front_page, m_swp, m_fp);
            end
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            tests++;
            if (disp_rvalid !== exp_v || (exp_v && disp_rdata !== q[0].data)) begin
                fails++;
                $display("FAIL rnd_rd cyc=%0d rvalid=%b rdata=%h exp %b/%h",
                         cyc, disp_rvalid, disp_rdata, exp_v,
                         exp_v ? q[0].data : '0);
            end
            if (exp_v) void'(q.pop_front());
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_read_burst();
        test_swap();
        test_same_edge();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
